// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;
   localparam int UART_BYTE_W = 8;
   localparam logic [UART_BYTE_W-1:0] ASCII_CR = 8'h0D;
   localparam logic [UART_BYTE_W-1:0] ASCII_LF = 8'h0A;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_HI,
      WAIT_LO,
      CRLF_SEL
   } feeder_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with occupancy count; read data is the current head entry.
module uart_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; pointers and count alone define validity.
   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers a byte stream and sequences it into the UART TX trigger/busy handshake.
// Build option UART_TX_FEEDER_CRLF_EN appends CR LF after each byte tagged last.
//
// state    | meaning
// IDLE     | waiting for a queued byte and an idle transmitter
// TRIG     | trigger pulse is on the wire this cycle
// WAIT_HI  | waiting for busy to rise, bounded by a down-counter
// WAIT_LO  | transmitter busy, waiting for it to finish
// CRLF_SEL | selecting the next CR or LF byte to send
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int WAIT_HI_TIMEOUT = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [7:0]               data_in,
   input  logic                     valid_in,
   input  logic                     last_in,
   output logic                     ready_out,
   input  logic                     tx_busy_in,
   output logic [7:0]               tx_data_out,
   output logic                     tx_trigger_out,
   output logic [$clog2(DEPTH):0]   fill_out,
   output logic                     idle_out
);
`ifdef UART_TX_FEEDER_CRLF_EN
   localparam int EW = UART_BYTE_W + 1;
`else
   localparam int EW = UART_BYTE_W;
`endif
   localparam int TW = $clog2(WAIT_HI_TIMEOUT + 1);

   feeder_state_t   state_q, state_d;
   logic [7:0]      data_q, data_d;
   logic            trig_q, trig_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            pop;
   logic            done;
   logic            full;
   logic            empty;
   logic [EW-1:0]   wr_entry;
   logic [EW-1:0]   head;

`ifdef UART_TX_FEEDER_CRLF_EN
   logic [1:0]      crlf_q, crlf_d;
   assign wr_entry = {last_in, data_in};
`else
   logic            unused_last;
   assign unused_last = last_in;
   assign wr_entry    = data_in;
`endif

   uart_byte_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push    (valid_in),
      .pop     (pop),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (fill_out)
   );

   assign ready_out      = !full;
   assign tx_data_out    = data_q;
   assign tx_trigger_out = trig_q;
   assign idle_out       = empty && (state_q == IDLE) && !tx_busy_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         data_q  <= '0;
         trig_q  <= 1'b0;
         tmr_q   <= '0;
`ifdef UART_TX_FEEDER_CRLF_EN
         crlf_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         trig_q  <= trig_d;
         tmr_q   <= tmr_d;
`ifdef UART_TX_FEEDER_CRLF_EN
         crlf_q  <= crlf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      trig_d  = 1'b0;
      tmr_d   = tmr_q;
      pop     = 1'b0;
      done    = 1'b0;
`ifdef UART_TX_FEEDER_CRLF_EN
      crlf_d  = crlf_q;
`endif
      case (state_q)
         IDLE: begin
            if (!empty && !tx_busy_in) begin
               pop     = 1'b1;
               data_d  = head[UART_BYTE_W-1:0];
               trig_d  = 1'b1;
               state_d = TRIG;
`ifdef UART_TX_FEEDER_CRLF_EN
               crlf_d  = head[EW-1] ? 2'd2 : 2'd0;
`endif
            end
         end
         TRIG: begin
            tmr_d   = TW'(WAIT_HI_TIMEOUT - 1);
            state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (tx_busy_in)          state_d = WAIT_LO;
            else if (tmr_q == '0)    done    = 1'b1;
            else                     tmr_d   = tmr_q - TW'(1);
         end
         WAIT_LO: begin
            if (!tx_busy_in) done = 1'b1;
         end
         CRLF_SEL: begin
`ifdef UART_TX_FEEDER_CRLF_EN
            if (!tx_busy_in) begin
               data_d  = (crlf_q == 2'd2) ? ASCII_CR : ASCII_LF;
               trig_d  = 1'b1;
               crlf_d  = crlf_q - 2'd1;
               state_d = TRIG;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase

      // A finished byte (busy fell or the rise timed out) may owe a CR/LF tail.
      if (done) begin
`ifdef UART_TX_FEEDER_CRLF_EN
         state_d = (crlf_q != 2'd0) ? CRLF_SEL : IDLE;
`else
         state_d = IDLE;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple transmitter busy model.
module tb_uart_tx_feeder;
   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [7:0] data_in;
   logic       valid_in;
   logic       last_in;
   logic       ready_out;
   logic       tx_busy_in;
   logic [7:0] tx_data_out;
   logic       tx_trigger_out;
   logic [4:0] fill_out;
   logic       idle_out;

   uart_tx_feeder #(.DEPTH(16), .WAIT_HI_TIMEOUT(4)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .data_in        (data_in),
      .valid_in       (valid_in),
      .last_in        (last_in),
      .ready_out      (ready_out),
      .tx_busy_in     (tx_busy_in),
      .tx_data_out    (tx_data_out),
      .tx_trigger_out (tx_trigger_out),
      .fill_out       (fill_out),
      .idle_out       (idle_out)
   );

   always #5 clk_in = ~clk_in;

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          trig_cnt = 0;
   int          push_cyc = 0;
   int          busy_len = 20;
   int          busy_cnt = 0;
   bit          never_busy = 1'b0;
   logic        ext_busy = 1'b0;
   logic        model_busy = 1'b0;
   logic        prev_trig = 1'b0;
   logic [7:0]  exp_q[$];
   int          trig_cycs[$];

   assign tx_busy_in = model_busy | ext_busy;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
   endtask

   always @(posedge clk_in) cyc++;

   // Output monitor and transmitter model share the falling edge.
   always @(negedge clk_in) begin
      if (tx_trigger_out) begin
         check_eq("trig_width", {31'd0, prev_trig}, 32'd0);
         trig_cnt++;
         trig_cycs.push_back(cyc);
         if (exp_q.size() == 0) check_eq("unexpected_trig", {24'd0, tx_data_out}, 32'h100);
         else                   check_eq("tx_data", {24'd0, tx_data_out}, {24'd0, exp_q.pop_front()});
      end
      prev_trig = tx_trigger_out;
      if (rst_in)                             busy_cnt = 0;
      else if (tx_trigger_out && !never_busy) busy_cnt = busy_len;
      else if (busy_cnt > 0)                  busy_cnt--;
      model_busy = (busy_cnt > 0);
   end

   task automatic push_byte(input logic [7:0] b, input logic last);
      int   t;
      logic acc;
      t   = 0;
      acc = 1'b0;
      @(negedge clk_in);
      data_in  = b;
      last_in  = last;
      valid_in = 1'b1;
      while (!acc && t < 2000) begin
         acc      = ready_out;
         push_cyc = cyc;
         @(posedge clk_in);
         if (!acc) begin
            @(negedge clk_in);
            t++;
         end
      end
      check_eq("push_accept", {31'd0, acc}, 32'd1);
      if (acc) begin
         exp_q.push_back(b);
`ifdef UART_TX_FEEDER_CRLF_EN
         if (last) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
         end
`endif
      end
   endtask

   task automatic drop_valid();
      @(negedge clk_in);
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while (!(idle_out && exp_q.size() == 0) && t < budget) begin
         @(negedge clk_in);
         t++;
      end
      check_eq("drain_in_time", {31'd0, t < budget}, 32'd1);
   endtask

   initial begin
      int c0;
      int t;
      rst_in   = 1'b1;
      data_in  = 8'h00;
      valid_in = 1'b0;
      last_in  = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check_eq("rst_trig",  {31'd0, tx_trigger_out}, 32'd0);
      check_eq("rst_data",  {24'd0, tx_data_out}, 32'h00);
      check_eq("rst_fill",  {27'd0, fill_out}, 32'd0);
      check_eq("rst_ready", {31'd0, ready_out}, 32'd1);
      check_eq("rst_idle",  {31'd0, idle_out}, 32'd1);
      rst_in = 1'b0;

      // Single byte, latency and hold
      busy_len = 20;
      trig_cycs.delete();
      push_byte(8'hA5, 1'b0);
      drop_valid();
      t = 0;
      while (trig_cycs.size() == 0 && t < 50) begin @(negedge clk_in); t++; end
      check_eq("single_trig_seen", trig_cycs.size(), 32'd1);
      if (trig_cycs.size() > 0) check_eq("single_latency", trig_cycs[0] - push_cyc, 32'd2);
      repeat (5) @(negedge clk_in);
      check_eq("busy_not_idle", {31'd0, idle_out}, 32'd0);
      check_eq("data_hold", {24'd0, tx_data_out}, 32'hA5);
      wait_idle(200);
      check_eq("idle_after", {31'd0, idle_out}, 32'd1);

      // Fill to full while the transmitter is held busy; 17th byte must wait
      busy_len = 3;
      c0 = trig_cnt;
      ext_busy = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
      drop_valid();
      check_eq("full_fill",  {27'd0, fill_out}, 32'd16);
      check_eq("full_ready", {31'd0, ready_out}, 32'd0);
      fork
         begin
            push_byte(8'h10, 1'b0);
            drop_valid();
         end
         begin
            repeat (5) @(negedge clk_in);
            check_eq("held_fill",  {27'd0, fill_out}, 32'd16);
            check_eq("held_ready", {31'd0, ready_out}, 32'd0);
            ext_busy = 1'b0;
         end
      join
      wait_idle(2000);
      check_eq("burst_trigs", trig_cnt - c0, 32'd17);

      // Push and pop on the same edge at fill 5, then 40 bytes through the pointers
      ext_busy = 1'b1;
      for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i), 1'b0);
      drop_valid();
      check_eq("fill5", {27'd0, fill_out}, 32'd5);
      @(negedge clk_in);
      ext_busy = 1'b0;
      data_in  = 8'h25;
      valid_in = 1'b1;
      @(posedge clk_in);
      exp_q.push_back(8'h25);
      @(negedge clk_in);
      valid_in = 1'b0;
      check_eq("same_edge_fill", {27'd0, fill_out}, 32'd5);
      check_eq("same_edge_trig", {31'd0, tx_trigger_out}, 32'd1);
      busy_len = 2;
      for (int i = 0; i < 40; i++) push_byte(8'h40 + 8'(i), 1'b0);
      drop_valid();
      wait_idle(3000);

      // Transmitter never raises busy: WAIT_HI times out
      never_busy = 1'b1;
      trig_cycs.delete();
      for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 1'b0);
      drop_valid();
      wait_idle(200);
      check_eq("timeout_trigs", trig_cycs.size(), 32'd3);
      if (trig_cycs.size() == 3) begin
         check_eq("timeout_gap0", trig_cycs[1] - trig_cycs[0], 32'd6);
         check_eq("timeout_gap1", trig_cycs[2] - trig_cycs[1], 32'd6);
      end
      never_busy = 1'b0;

      // Reset in WAIT_LO with 7 queued
      busy_len = 60;
      c0 = trig_cnt;
      push_byte(8'h30, 1'b0);
      drop_valid();
      t = 0;
      while (trig_cnt == c0 && t < 50) begin @(negedge clk_in); t++; end
      repeat (3) @(negedge clk_in);
      for (int i = 0; i < 7; i++) push_byte(8'h31 + 8'(i), 1'b0);
      drop_valid();
      check_eq("pre_rst_fill", {27'd0, fill_out}, 32'd7);
      rst_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      check_eq("rst_mid_fill",  {27'd0, fill_out}, 32'd0);
      check_eq("rst_mid_trig",  {31'd0, tx_trigger_out}, 32'd0);
      check_eq("rst_mid_ready", {31'd0, ready_out}, 32'd1);
      rst_in = 1'b0;
      exp_q.delete();
      c0 = trig_cnt;
      repeat (30) @(negedge clk_in);
      check_eq("no_trig_after_rst", trig_cnt - c0, 32'd0);

      // Last-tagged byte: CR/LF appended only when the option is built in
      busy_len = 4;
      c0 = trig_cnt;
      push_byte(8'h41, 1'b0);
      push_byte(8'h42, 1'b1);
      drop_valid();
      wait_idle(500);
      repeat (30) @(negedge clk_in);
`ifdef UART_TX_FEEDER_CRLF_EN
      check_eq("crlf_trigs", trig_cnt - c0, 32'd4);
`else
      check_eq("crlf_trigs", trig_cnt - c0, 32'd2);
`endif
      check_eq("final_idle", {31'd0, idle_out}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish, checks %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end
endmodule
